// File: rtl/sample_serializer_if.sv
// rtl/sample_serializer_if.sv - parallel sample push handshake into the serializer FIFO
interface sample_serializer_if #(
    parameter int WIDTH = 12
) ();
    logic [0:WIDTH-1] s_data;
    logic             s_valid;
    logic             s_ready;

    modport master (
        output s_data,
        output s_valid,
        input  s_ready
    );

    modport slave (
        input  s_data,
        input  s_valid,
        output s_ready
    );
endinterface

// File: rtl/sample_serializer.sv
// rtl/sample_serializer.sv - FIFO-buffered MSB-first sample serializer with zero-fill on underrun
module sample_serializer #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    sample_serializer_if.slave       s,
    output logic                     sout,
    output logic                     sync,
    output logic                     underrun,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH) + 1;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH);

    localparam logic [0:0] STATE_IDLE = 1'b0;
    localparam logic [0:0] STATE_RUN  = 1'b1;

    logic [0:0]       state;
    logic [0:WIDTH-1] shreg;
    logic [CW-1:0]    bit_cnt;
    logic [0:WIDTH-1] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    logic             push;
    logic             pop;
    logic             empty;
    logic             at_boundary;
    logic             load;
    logic [0:WIDTH-1] load_word;

    // s_ready depends only on registered occupancy, never on a same-cycle pop
    assign s.s_ready   = (level < DEPTH_L);
    assign push        = s.s_valid && s.s_ready;
    assign empty       = (level == '0);
    assign at_boundary = (state == STATE_RUN) && (bit_cnt == LAST_CNT);
    assign load        = en && ((state == STATE_IDLE) || at_boundary);
    assign pop         = load && !empty;
    assign load_word   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s.s_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // A load emits bit 0 on the same edge, so the counter names the next bit to send
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= STATE_IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            sout     <= 1'b0;
            sync     <= 1'b0;
            underrun <= 1'b0;
        end else begin
            underrun <= load && empty;
            if (load) begin
                state   <= STATE_RUN;
                shreg   <= load_word;
                sout    <= load_word[0];
                sync    <= 1'b1;
                bit_cnt <= CW'(1);
            end else if (state == STATE_RUN) begin
                if (at_boundary) begin
                    state   <= STATE_IDLE;
                    sout    <= 1'b0;
                    sync    <= 1'b0;
                    bit_cnt <= '0;
                end else begin
                    sout    <= shreg[bit_cnt];
                    sync    <= 1'b0;
                    bit_cnt <= bit_cnt + CW'(1);
                end
            end else begin
                sout <= 1'b0;
                sync <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sample_serializer.sv
// tb/tb_sample_serializer.sv - scoreboard bench for sample_serializer
module tb_sample_serializer;
    localparam int W = 12;
    localparam int D = 4;

    typedef struct packed {
        logic [0:W-1] data;
        logic         ur;
        logic         contig;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b0;
    logic       sout;
    logic       sync;
    logic       underrun;
    logic [2:0] level;

    int checks = 0;
    int passes = 0;

    exp_t         exp_q[$];
    exp_t         cur;
    logic         mon_en = 1'b1;
    logic         in_word = 1'b0;
    logic [0:W-1] got;
    logic         ur_first;
    logic         stray;
    int           bit_i;
    int           gap;

    sample_serializer_if #(.WIDTH(W)) s_if ();

    sample_serializer #(.WIDTH(W), .DEPTH(D)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .s        (s_if),
        .sout     (sout),
        .sync     (sync),
        .underrun (underrun),
        .level    (level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s actual=%h required=%h", name, act, req);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [0:W-1] d);
        s_if.s_data  = d;
        s_if.s_valid = 1'b1;
        tick();
        s_if.s_valid = 1'b0;
    endtask

    task automatic expect_word(input logic [0:W-1] d, input logic ur, input logic contig);
        exp_t e;
        e.data   = d;
        e.ur     = ur;
        e.contig = contig;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || in_word) && n < 300) begin
            tick();
            n++;
        end
        chk("drain_timeout", n < 300, 1);
    endtask

    initial begin
        gap = 0;
        bit_i = 0;
        forever begin
            @(negedge clk);
            if (!rst_n || !mon_en) begin
                in_word = 1'b0;
                gap = 0;
            end else if (in_word) begin
                got[bit_i] = sout;
                if (sync || underrun) stray = 1'b1;
                bit_i++;
                if (bit_i == W) begin
                    chk("word_data", {20'b0, got}, {20'b0, cur.data});
                    chk("word_underrun", ur_first, cur.ur);
                    chk("stray_sync_underrun", stray, 0);
                    in_word = 1'b0;
                    gap = 0;
                end
            end else if (sync) begin
                chk("word_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) cur = exp_q.pop_front();
                else cur = '0;
                if (cur.contig) chk("contiguous", gap, 0);
                got = '0;
                got[0] = sout;
                ur_first = underrun;
                stray = 1'b0;
                bit_i = 1;
                in_word = 1'b1;
            end else begin
                gap++;
                if (underrun) chk("underrun_idle", underrun, 0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        s_if.s_data  = '0;
        s_if.s_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_sout", sout, 0);
        chk("reset_sync", sync, 0);
        chk("reset_underrun", underrun, 0);
        chk("reset_level", level, 0);
        chk("reset_s_ready", s_if.s_ready, 1);
        tick();
        rst_n = 1'b1;
        tick();

        // single word pushed while idle
        push_word(12'h032);
        chk("level_after_push", level, 1);
        expect_word(12'h032, 1'b0, 1'b0);
        en = 1'b1;
        tick();
        en = 1'b0;
        wait_drain();
        tick();
        chk("idle_sout_1", sout, 0);

        // two contiguous words, including a negative sample
        push_word(12'hFF3);
        push_word(12'h014);
        expect_word(12'hFF3, 1'b0, 1'b0);
        expect_word(12'h014, 1'b0, 1'b1);
        en = 1'b1;
        repeat (13) tick();
        en = 1'b0;
        wait_drain();

        // fill to full, fifth push refused
        for (int i = 0; i < 5; i++) begin
            logic [0:W-1] wv [5];
            wv = '{12'h001, 12'h800, 12'hA5A, 12'h7FF, 12'h123};
            s_if.s_data  = wv[i];
            s_if.s_valid = 1'b1;
            if (i == 4) chk("s_ready_full", s_if.s_ready, 0);
            tick();
        end
        s_if.s_valid = 1'b0;
        chk("level_full", level, 4);
        expect_word(12'h001, 1'b0, 1'b0);
        expect_word(12'h800, 1'b0, 1'b1);
        expect_word(12'hA5A, 1'b0, 1'b1);
        expect_word(12'h7FF, 1'b0, 1'b1);
        en = 1'b1;
        tick();
        chk("s_ready_after_load", s_if.s_ready, 1);
        chk("level_after_load", level, 3);
        repeat (36) tick();
        en = 1'b0;
        wait_drain();
        chk("level_empty", level, 0);

        // underrun word, then a mid-word push goes out on the next word
        expect_word(12'h000, 1'b1, 1'b0);
        expect_word(12'h073, 1'b0, 1'b1);
        en = 1'b1;
        tick();
        repeat (3) tick();
        push_word(12'h073);
        repeat (8) tick();
        en = 1'b0;
        wait_drain();

        // en dropped at bit 5 still completes the word
        push_word(12'h5A3);
        expect_word(12'h5A3, 1'b0, 1'b0);
        en = 1'b1;
        tick();
        repeat (5) tick();
        en = 1'b0;
        wait_drain();
        tick();
        chk("idle_sout_2", sout, 0);
        chk("idle_sync_2", sync, 0);

        // reset at bit 3 aborts the word and flushes the FIFO
        push_word(12'h9C6);
        push_word(12'h111);
        mon_en = 1'b0;
        en = 1'b1;
        tick();
        repeat (3) tick();
        rst_n = 1'b0;
        en = 1'b0;
        #1;
        chk("midreset_sout", sout, 0);
        chk("midreset_level", level, 0);
        chk("midreset_sync", sync, 0);
        chk("midreset_s_ready", s_if.s_ready, 1);
        tick();
        rst_n = 1'b1;
        mon_en = 1'b1;
        repeat (3) tick();
        chk("post_reset_sout", sout, 0);
        chk("post_reset_level", level, 0);
        expect_word(12'h000, 1'b1, 1'b0);
        en = 1'b1;
        tick();
        en = 1'b0;
        wait_drain();
        repeat (3) tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/sample_serializer.md
SAMPLE_SERIALIZER -- requirements
Module: sample_serializer

Interface
REQ-001 SHALL have parameter: WIDTH, 12, bits per serial word.
REQ-002 SHALL have parameter: DEPTH, 4, input FIFO depth in words (power of two).
REQ-003 SHALL have port: clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: en  input  1  stream enable; 1 = transmit continuously.
REQ-006 SHALL have port: s_data  input  WIDTH  parallel two's-complement sample; index 0 is MSB.
REQ-007 SHALL have port: s_valid  input  1  s_data valid.
REQ-008 SHALL have port: s_ready  output  1  FIFO can accept a word.
REQ-009 SHALL have port: sout  output  1  serial bit stream, registered.
REQ-010 SHALL have port: sync  output  1  registered; high during the first bit of each word.
REQ-011 SHALL have port: underrun  output  1  registered one-cycle pulse when a zero fill word starts.
REQ-012 SHALL have port: level  output  clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-013 SHALL accept a word on any rising edge with s_valid=1 and s_ready=1.
REQ-014 SHALL drive s_ready = (level < DEPTH), independent of a same-cycle pop; a push is never accepted when full.
REQ-015 SHALL count push and pop in the same cycle with net level change 0.
REQ-016 SHALL implement two states: IDLE and RUN.
REQ-017 IDLE: sout=0, sync=0, no pops; at an edge with en=1, go to RUN and load the first word on that same edge.
REQ-018 Word load: shift register takes FIFO head (pop) or, if FIFO empty, all zeros; sout <= word[0]; sync <= 1; bit counter <= 1.
REQ-019 Each following edge in RUN: sout <= word[bit counter]; sync <= 0; counter increments.
REQ-020 After bit WIDTH-1 is output, the next edge SHALL load the next word; no gap cycles; word period is exactly WIDTH cycles.
REQ-021 Bits SHALL go out index 0 (MSB) first, index WIDTH-1 last.
REQ-022 underrun SHALL pulse high on the same edge as a zero-fill load, and only then.
REQ-023 A word pushed into an empty FIFO mid-word SHALL be sent at the next word boundary, not the current word.
REQ-024 If en=0 at a word boundary, SHALL go to IDLE instead of loading; en=0 mid-word SHALL NOT truncate the current word.
REQ-025 FIFO contents SHALL persist across IDLE; pushes SHALL be allowed in IDLE.
REQ-026 Level SHALL never exceed DEPTH or go below 0; read/write pointers wrap modulo DEPTH.

Reset
REQ-027 rst_n=0 SHALL immediately force: state=IDLE, sout=0, sync=0, underrun=0, level=0, s_ready=1, counter=0, pointers=0.
REQ-028 Reset mid-word SHALL abort the word and flush the FIFO; after release, transmission resumes only per REQ-017.

Verification
REQ-029 Push 50 (0x032) in IDLE, then en=1 -> sout = 0,0,0,0,0,0,1,1,0,0,1,0 over 12 cycles; sync high only on the first; underrun=0.
REQ-030 Push -13 (0xFF3) and 20 (0x014), en=1 -> 24 contiguous bits 111111110011 000000010100; sync high at cycles 0 and 12.
REQ-031 Push 5 words back-to-back with en=0 -> 4 accepted, s_ready=0 on the 5th, level=4; en=1 -> s_ready=1 after first load.
REQ-032 en=1 with empty FIFO -> 12 zero bits, sync and underrun high on the first; push 115 mid-word -> 0x073 sent next word, no underrun.
REQ-033 en dropped at bit 5 of word -> remaining 6 bits sent, then IDLE with sout=0; rst_n low at bit 3 -> sout=0, level=0 immediately.
